fifo_stream_drain: RTL and testbench

//  Read-side drain for the synchronous fifo (DEPTH 16, WIDTH 8).

---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_skid_buf.sv | 38 +++
 rtl/fifo_stream_drain.sv | 63 ++++++
 tb/tb_fifo_stream_drain.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared fifo geometry, word type and a counter-width helper for the fifo read-side drain.
package fifo_pkg;
  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;
  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry in-order buffer that absorbs the fifo read latency; head is always on rdata.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       occ
);
  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       occ_q, occ_d;
  always_comb occ_d = occ_q + 2'(wr) - 2'(rd);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (wr) mem_q[wr_ptr_q] <= wdata;
      wr_ptr_q <= wr_ptr_q ^ wr;
      rd_ptr_q <= rd_ptr_q ^ rd;
      occ_q    <= occ_d;
    end
  end
  assign rdata = mem_q[rd_ptr_q];
  assign occ   = occ_q;
  // The upstream reservation must never let a capture land on a full buffer or a pop hit an empty one.
  assert property (@(posedge clk) disable iff (!rst_n) !(wr && !rd && occ_q == 2'd2));
  assert property (@(posedge clk) disable iff (!rst_n) !(rd && occ_q == 2'd0));
endmodule

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: pulls words from the fifo into a valid/ready stream framed in PKT_LEN-beat packets.
// Define FIFO_DRAIN_CNT_EN to add the 32-bit xfer_cnt output counting accepted beats.
module fifo_stream_drain
  import fifo_pkg::*;
#(
  parameter int WIDTH   = FIFO_WIDTH,
  parameter int PKT_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [31:0]      xfer_cnt
`endif
);
  localparam int CW = cnt_width(PKT_LEN);
  localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);
  logic          inflight_q;
  logic [1:0]    occ;
  logic          pop;
  logic [2:0]    pend;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  fifo_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst),
    .wr    (inflight_q),
    .wdata (fifo_data),
    .rd    (pop),
    .rdata (m_data),
    .occ   (occ)
  );
  assign m_valid = occ != 2'd0;
  assign pop     = m_valid && m_ready;
  // Slots already claimed after this edge: buffered plus in flight, minus the beat leaving now.
  assign pend    = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
  assign rd_en   = rst && !fifo_empty && pend < 3'd2;
  assign m_last  = m_valid && beat_cnt_q == LAST;
  always_comb beat_cnt_d = !pop ? beat_cnt_q : (beat_cnt_q == LAST) ? '0 : beat_cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      inflight_q <= rd_en;
      beat_cnt_q <= beat_cnt_d;
    end
  end
`ifdef FIFO_DRAIN_CNT_EN
  logic [31:0] xfer_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) xfer_cnt_q <= '0;
    else      xfer_cnt_q <= xfer_cnt_q + 32'(pop);
  end
  assign xfer_cnt = xfer_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain: random/directed stimulus with a behavioural fifo and an in-order scoreboard.
module tb_fifo_stream_drain;
  localparam int W  = 8;
  localparam int PL = 16;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_data = '0;
  logic         rd_en, m_valid, m_last;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
`ifdef FIFO_DRAIN_CNT_EN
  logic [31:0]  xfer_cnt;
`endif
  typedef struct {logic [W-1:0] d; logic l;} exp_t;
  logic [W-1:0] pq[$];
  logic [W-1:0] fq[$];
  exp_t         sb[$];
  int checks = 0, errors = 0;
  int sent = 0, cyc = 0, rd_pulses = 0, nvalid = 0;
  int first_rd = -1, first_valid = -1, first_pop = -1, last_pop = -1;
  logic         hold_q = 1'b0;
  logic [W-1:0] hold_d = '0;

  fifo_stream_drain #(.WIDTH(W), .PKT_LEN(PL)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .rd_en      (rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
`ifdef FIFO_DRAIN_CNT_EN
    ,
    .xfer_cnt   (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural 16-deep fifo: data_out registered on a sampled rd_en, empty flag updated after the edge.
  always @(posedge clk) begin
    if (rd_en) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL underflow: rd_en=1 with fifo size 0, required no read");
      end else fifo_data <= fq.pop_front();
    end
    while (pq.size() > 0 && fq.size() < 16) fq.push_back(pq.pop_front());
    fifo_empty <= (fq.size() == 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ({rd_en, m_valid, m_data, m_last} != '0) begin
        errors++;
        $display("FAIL reset_out: rd_en=%0b m_valid=%0b m_data=%0h m_last=%0b, required all 0", rd_en, m_valid, m_data, m_last);
      end
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        checks++;
        if (!m_valid || m_data != hold_d) begin
          errors++;
          $display("FAIL hold: m_valid=%0b m_data=%0h, required 1/%0h", m_valid, m_data, hold_d);
        end
      end
      if (m_last && !m_valid) begin
        errors++;
        $display("FAIL last_qual: m_last=1 with m_valid=0, required m_last=0");
      end
      if (m_valid && m_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got %0h last=%0b, required no beat", m_data, m_last);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (m_data != e.d || m_last != e.l) begin
            errors++;
            $display("FAIL beat: got %0h last=%0b, required %0h last=%0b", m_data, m_last, e.d, e.l);
          end
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (rd_en) begin
        rd_pulses++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (m_valid) begin
        nvalid++;
        if (first_valid < 0) first_valid = cyc;
      end
      hold_q = m_valid && !m_ready;
      hold_d = m_data;
    end
    cyc++;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    exp_t e;
    e.d = d;
    e.l = (sent % PL) == PL - 1;
    pq.push_back(d);
    sb.push_back(e);
    sent++;
  endtask

  task automatic drain(input string nm, input int lim);
    int n = 0;
    while (sb.size() > 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    #1 chk(nm, sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    // Empty fifo: nothing must be read or presented.
    m_ready = 1'b1;
    rd_pulses = 0;
    nvalid = 0;
    repeat (20) @(posedge clk);
    #1 chk("empty_rd_pulses", rd_pulses, 0);
    chk("empty_valid_cycles", nvalid, 0);
    // Preloaded 0..15 with m_ready held high.
    first_rd = -1; first_valid = -1; first_pop = -1; last_pop = -1;
    for (int i = 0; i < 16; i++) push(W'(i));
    drain("stream_drain", 100);
    chk("latency", first_valid - first_rd, 2);
    chk("throughput_span", last_pop - first_pop, 15);
    repeat (3) @(posedge clk);
    #1 chk("idle_valid", m_valid, 0);
`ifdef FIFO_DRAIN_CNT_EN
    chk("xfer_cnt", xfer_cnt, 16);
`endif
    // Backpressured: exactly two reads, head held.
    m_ready = 1'b0;
    rd_pulses = 0;
    for (int i = 0; i < 16; i++) push(W'(i));
    repeat (20) @(posedge clk);
    #1 chk("stall_rd_pulses", rd_pulses, 2);
    chk("stall_valid", m_valid, 1);
    chk("stall_data", m_data, 0);
    // Toggling ready.
    for (int n = 0; n < 200 && sb.size() > 0; n++) begin
      m_ready = ~m_ready;
      @(posedge clk);
      #1;
    end
    chk("toggle_left", sb.size(), 0);
    // Random ready and random arrivals.
    for (int n = 0; n < 400; n++) begin
      m_ready = $urandom_range(0, 3) != 0;
      if (pq.size() + fq.size() < 16 && $urandom_range(0, 2) != 0) push(W'($urandom));
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    drain("random_drain", 100);
    // Asynchronous reset mid-stream.
    for (int i = 0; i < 10; i++) push(W'(8'h80 + i));
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("async_rd_en", rd_en, 0);
    chk("async_valid", m_valid, 0);
    chk("async_last", m_last, 0);
`ifdef FIFO_DRAIN_CNT_EN
    chk("xfer_cnt_reset", xfer_cnt, 0);
`endif
    pq.delete();
    fq.delete();
    sb.delete();
    sent = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 20; i++) push(W'(8'h40 + i));
    drain("post_reset_drain", 200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1);
  end
endmodule
